// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-lite master driven by a valid/ready command stream.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to enable the sticky watchdog on the timeout output.
module axil_cmd_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready,
   output logic                  busy,
   output logic                  timeout
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [2:0] prot_q, prot_d;
   logic [1:0] resp_q, resp_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic bready_q, bready_d, rready_q, rready_d;
   logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic cmd_accept;
   assign cmd_ready  = (state_q == IDLE) && !rst;
   assign cmd_accept = cmd_valid && cmd_ready;
   assign busy       = state_q != IDLE;
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      prot_d      = prot_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            addr_d    = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            prot_d    = cmd_prot;
            awvalid_d = cmd_write;
            wvalid_d  = cmd_write;
            arvalid_d = !cmd_write;
            state_d   = cmd_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            // AW and W retire independently; move on only once both are gone
            awvalid_d = awvalid_q && !m_axil_awready;
            wvalid_d  = wvalid_q && !m_axil_wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: if (m_axil_bvalid) begin
            bready_d    = 1'b0;
            resp_d      = m_axil_bresp;
            rdata_d     = '0;
            rsp_write_d = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RD_REQ: if (m_axil_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_RESP;
         end
         RD_RESP: if (m_axil_rvalid) begin
            rready_d    = 1'b0;
            resp_d      = m_axil_rresp;
            rdata_d     = m_axil_rdata;
            rsp_write_d = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         prot_q      <= '0;
         rdata_q     <= '0;
         resp_q      <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         prot_q      <= prot_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
      end
   end
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = prot_q;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = prot_q;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_write      = rsp_write_q;
   assign rsp_rdata      = rdata_q;
   assign rsp_resp       = resp_q;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES+1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic timeout_q, timeout_d, in_xfer;
   assign in_xfer = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
   always_comb begin
      cnt_d     = cmd_accept ? '0 : (in_xfer && cnt_q != CW'(TIMEOUT_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
      timeout_d = timeout_q || (cnt_d == CW'(TIMEOUT_CYCLES));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed checks of the command-to-AXI4-lite master.
module tb_axil_cmd_master;
   logic clk, rst;
   logic cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0] cmd_wstrb;
   logic [2:0] cmd_prot;
   logic rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0] rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;
   logic busy, timeout;
   int checks = 0;
   int errors = 0;

   axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
      .busy(busy), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic quiet_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; cmd_prot = 0;
      rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
   endtask

   task automatic test_reset();
      rst = 1; quiet_inputs();
      repeat (2) @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset cmd_ready got %b exp 0", cmd_ready); end
      checks++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin errors++; $display("FAIL reset valids got %b exp 000", {awvalid, wvalid, arvalid}); end
      checks++; if ({bready, rready, rsp_valid, busy} !== 4'b0000) begin errors++; $display("FAIL reset ready/rsp/busy got %b exp 0000", {bready, rready, rsp_valid, busy}); end
      checks++; if ({awaddr, wdata, wstrb, awprot} !== 71'd0) begin errors++; $display("FAIL reset payload got %h exp 0", {awaddr, wdata, wstrb, awprot}); end
      checks++; if ({rsp_rdata, rsp_resp, rsp_write} !== 35'd0) begin errors++; $display("FAIL reset rsp payload got %h exp 0", {rsp_rdata, rsp_resp, rsp_write}); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset timeout got %b exp 0", timeout); end
      rst = 0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release cmd_ready got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write_basic();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF; cmd_prot = 3'b010;
      awready = 1; wready = 1; rsp_ready = 1;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr_basic c1 aw/wvalid got %b exp 11", {awvalid, wvalid}); end
      checks++; if (awaddr !== 32'h10) begin errors++; $display("FAIL wr_basic awaddr got %h exp 10", awaddr); end
      checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_basic wdata got %h exp deadbeef", wdata); end
      checks++; if ({wstrb, awprot} !== 7'b1111_010) begin errors++; $display("FAIL wr_basic wstrb/awprot got %b exp 1111010", {wstrb, awprot}); end
      checks++; if ({busy, cmd_ready, bready, arvalid} !== 4'b1000) begin errors++; $display("FAIL wr_basic c1 busy/cmd_ready/bready/arvalid got %b exp 1000", {busy, cmd_ready, bready, arvalid}); end
      @(negedge clk);
      checks++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin errors++; $display("FAIL wr_basic c2 aw/w/bready/rsp got %b exp 0010", {awvalid, wvalid, bready, rsp_valid}); end
      bvalid = 1; bresp = 2'b00;
      @(negedge clk);
      bvalid = 0;
      checks++; if ({rsp_valid, rsp_write, bready} !== 3'b110) begin errors++; $display("FAIL wr_basic c3 rsp_valid/rsp_write/bready got %b exp 110", {rsp_valid, rsp_write, bready}); end
      checks++; if ({rsp_resp, rsp_rdata} !== 34'd0) begin errors++; $display("FAIL wr_basic rsp_resp/rdata got %h exp 0", {rsp_resp, rsp_rdata}); end
      @(negedge clk);
      checks++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin errors++; $display("FAIL wr_basic c4 cmd_ready/rsp_valid/busy got %b exp 100", {cmd_ready, rsp_valid, busy}); end
      quiet_inputs();
   endtask

   task automatic test_write_aw_stall();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 32'hA5A50F0F; cmd_wstrb = 4'h3; cmd_prot = 3'b001;
      awready = 0; wready = 1; rsp_ready = 1;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL aw_stall c1 aw/wvalid got %b exp 11", {awvalid, wvalid}); end
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL aw_stall c%0d aw/w/bready got %b exp 100", c, {awvalid, wvalid, bready}); end
         checks++; if ({awaddr, awprot} !== {32'h44, 3'b001}) begin errors++; $display("FAIL aw_stall c%0d awaddr/awprot got %h exp 44/1", c, {awaddr, awprot}); end
         if (c == 4) awready = 1;
      end
      @(negedge clk);
      awready = 0;
      checks++; if ({awvalid, bready} !== 2'b01) begin errors++; $display("FAIL aw_stall c5 awvalid/bready got %b exp 01", {awvalid, bready}); end
      bvalid = 1; bresp = 2'b01;
      @(negedge clk);
      bvalid = 0;
      checks++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1101) begin errors++; $display("FAIL aw_stall rsp got %b exp 1101", {rsp_valid, rsp_write, rsp_resp}); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL aw_stall cmd_ready got %b exp 1", cmd_ready); end
      quiet_inputs();
   endtask

   task automatic test_read();
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; cmd_prot = 3'b101; arready = 1; rsp_ready = 1;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if ({arvalid, rready, awvalid, wvalid} !== 4'b1000) begin errors++; $display("FAIL read c1 ar/rready/aw/w got %b exp 1000", {arvalid, rready, awvalid, wvalid}); end
      checks++; if ({araddr, arprot} !== {32'h20, 3'b101}) begin errors++; $display("FAIL read araddr/arprot got %h exp 20/5", {araddr, arprot}); end
      for (int c = 2; c <= 7; c++) begin
         @(negedge clk);
         checks++; if ({arvalid, rready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL read c%0d arvalid/rready/rsp_valid got %b exp 010", c, {arvalid, rready, rsp_valid}); end
         if (c == 7) begin rvalid = 1; rdata = 32'h12345678; rresp = 2'b10; end
      end
      @(negedge clk);
      rvalid = 0; arready = 0;
      checks++; if ({rsp_valid, rsp_write, rready} !== 3'b100) begin errors++; $display("FAIL read rsp_valid/rsp_write/rready got %b exp 100", {rsp_valid, rsp_write, rready}); end
      checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL read rsp_rdata got %h exp 12345678", rsp_rdata); end
      checks++; if (rsp_resp !== 2'b10) begin errors++; $display("FAIL read rsp_resp got %b exp 10", rsp_resp); end
      @(negedge clk);
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL read done cmd_ready/rsp_valid got %b exp 10", {cmd_ready, rsp_valid}); end
      quiet_inputs();
   endtask

   task automatic test_back_to_back();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
      awready = 1; wready = 1; rsp_ready = 0;
      @(negedge clk);
      cmd_write = 0; cmd_addr = 32'h34;
      checks++; if ({cmd_ready, awvalid, awaddr} !== {1'b0, 1'b1, 32'h30}) begin errors++; $display("FAIL b2b c1 cmd_ready/awvalid/awaddr got %h exp 0/1/30", {cmd_ready, awvalid, awaddr}); end
      @(negedge clk);
      checks++; if ({bready, cmd_ready} !== 2'b10) begin errors++; $display("FAIL b2b c2 bready/cmd_ready got %b exp 10", {bready, cmd_ready}); end
      bvalid = 1; bresp = 2'b00;
      for (int c = 3; c <= 6; c++) begin
         @(negedge clk);
         bvalid = 0;
         checks++; if ({rsp_valid, cmd_ready, rsp_write} !== 3'b101) begin errors++; $display("FAIL b2b c%0d rsp_valid/cmd_ready/rsp_write got %b exp 101", c, {rsp_valid, cmd_ready, rsp_write}); end
         checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b c%0d write rsp_rdata got %h exp 0", c, rsp_rdata); end
         if (c == 6) rsp_ready = 1;
      end
      @(negedge clk);
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL b2b c7 rsp_valid/cmd_ready got %b exp 01", {rsp_valid, cmd_ready}); end
      arready = 1; awready = 0; wready = 0;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if ({arvalid, busy, araddr} !== {1'b1, 1'b1, 32'h34}) begin errors++; $display("FAIL b2b c8 arvalid/busy/araddr got %h exp 1/1/34", {arvalid, busy, araddr}); end
      @(negedge clk);
      checks++; if (rready !== 1'b1) begin errors++; $display("FAIL b2b c9 rready got %b exp 1", rready); end
      rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b00;
      @(negedge clk);
      rvalid = 0;
      checks++; if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL b2b read rsp got %h exp 1/0/cafef00d", {rsp_valid, rsp_write, rsp_rdata}); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b done cmd_ready got %b exp 1", cmd_ready); end
      quiet_inputs();
   endtask

   task automatic test_reset_mid();
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50; arready = 0;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rst_mid c1 arvalid got %b exp 1", arvalid); end
      @(negedge clk);
      checks++; if ({arvalid, araddr} !== {1'b1, 32'h50}) begin errors++; $display("FAIL rst_mid c2 arvalid/araddr got %h exp 1/50", {arvalid, araddr}); end
      rst = 1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid cmd_ready in rst got %b exp 0", cmd_ready); end
      @(negedge clk);
      checks++; if ({arvalid, rready, rsp_valid, busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid after rst ar/r/rsp/busy got %b exp 0000", {arvalid, rready, rsp_valid, busy}); end
      checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL rst_mid araddr got %h exp 0", araddr); end
      rst = 0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid cmd_ready got %b exp 1", cmd_ready); end
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60; cmd_wdata = 32'h0BADCAFE; cmd_wstrb = 4'hC;
      awready = 1; wready = 1; rsp_ready = 1;
      @(negedge clk);
      cmd_valid = 0;
      checks++; if ({awvalid, wvalid, arvalid, awaddr} !== {3'b110, 32'h60}) begin errors++; $display("FAIL rst_mid fresh c1 got %h exp 6/60", {awvalid, wvalid, arvalid, awaddr}); end
      @(negedge clk);
      checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rst_mid fresh bready got %b exp 1", bready); end
      bvalid = 1; bresp = 2'b00;
      @(negedge clk);
      bvalid = 0;
      checks++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1100) begin errors++; $display("FAIL rst_mid fresh rsp got %b exp 1100", {rsp_valid, rsp_write, rsp_resp}); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid fresh done cmd_ready got %b exp 1", cmd_ready); end
      quiet_inputs();
   endtask

   task automatic test_timeout();
      logic exp;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h70; cmd_wdata = 32'h5; cmd_wstrb = 4'h1;
      awready = 1; wready = 1; rsp_ready = 1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         cmd_valid = 0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
         exp = (c >= 9);
`else
         exp = 1'b0;
`endif
         checks++; if (timeout !== exp) begin errors++; $display("FAIL timeout c%0d got %b exp %b", c, timeout, exp); end
         if (c == 11) begin bvalid = 1; bresp = 2'b00; end
      end
      @(negedge clk);
      bvalid = 0;
      checks++; if ({rsp_valid, rsp_write, timeout} !== {2'b11, exp}) begin errors++; $display("FAIL timeout rsp/timeout got %b exp 11%b", {rsp_valid, rsp_write, timeout}, exp); end
      @(negedge clk);
      checks++; if ({cmd_ready, timeout} !== {1'b1, exp}) begin errors++; $display("FAIL timeout sticky cmd_ready/timeout got %b exp 1%b", {cmd_ready, timeout}, exp); end
      rst = 1;
      @(negedge clk);
      rst = 0;
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout after rst got %b exp 0", timeout); end
      quiet_inputs();
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_aw_stall();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
